// File: rtl/serdes_sched_pkg.sv
// Shared types and defaults for the SerDes TX lane scheduler.
// Also provides the slot-counter width helper.
package serdes_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_e;

  localparam int unsigned DEF_WORD_CYCLES = 16;
  localparam int unsigned DEF_GAP_CYCLES  = 7;
  localparam logic [15:0] DEF_HDR_WORD    = 16'hC5AF;

  // Wide enough to hold max(WORD_CYCLES, GAP_CYCLES).
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned g);
    int unsigned m;
    m = (w > g) ? w : g;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin arbiter: search starts at ptr+1 and wraps.
// Returns a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IW'((32'(ptr_i) + off) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Shares one 16-bit serializer lane between N_REQ requesters: grant, word slot, zero gap.
// Optional header slot before each word when SERDES_HDR_INSERT_EN is defined.
module serdes_tx_scheduler
  import serdes_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WORD_CYCLES = DEF_WORD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter logic [15:0] HDR_WORD    = DEF_HDR_WORD
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic [N_REQ-1:0]           REQ_VALID,
  input  logic [16*N_REQ-1:0]        REQ_DATA,
  output logic [N_REQ-1:0]           REQ_READY,
  output logic [15:0]                PAR_OUT,
  output logic                       SER_START,
  output logic [$clog2(N_REQ)-1:0]   GRANT_ID,
  output logic                       BUSY
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CW    = cnt_width(WORD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] WORD_LOAD = CW'(WORD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  sched_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      par_q, par_d;
  logic             start_q, start_d;
  logic [IDX_W-1:0] gid_q, gid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
`ifdef SERDES_HDR_INSERT_EN
  logic [15:0]      hdr_buf_q, hdr_buf_d;
`endif

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             win;
  logic             fire;
  logic [15:0]      req_words [N_REQ];

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_arb (
    .req_i   (REQ_VALID),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_words[i] = REQ_DATA[16*i +: 16];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    start_d   = 1'b0;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
`ifdef SERDES_HDR_INSERT_EN
    hdr_buf_d = hdr_buf_q;
`endif

    win = 1'b0;
    case (state_q)
      ST_IDLE: win = 1'b1;
      ST_SEND: win = (cnt_q == '0) && (GAP_CYCLES == 0);
      ST_GAP:  win = (cnt_q == '0);
      default: win = 1'b0;
    endcase
    fire      = win && ENABLE && arb_valid;
    REQ_READY = fire ? arb_grant : '0;

    case (state_q)
      ST_IDLE: ;
      ST_SEND: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
          par_d   = '0;
        end else begin
          state_d = ST_IDLE;
          par_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ST_IDLE;
      end
`ifdef SERDES_HDR_INSERT_EN
      ST_HDR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_SEND;
          cnt_d   = WORD_LOAD;
          par_d   = hdr_buf_q;
          start_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        par_d   = '0;
      end
    endcase

    // An accept overrides the end-of-slot transition chosen above.
    if (fire) begin
      gid_d   = arb_idx;
      ptr_d   = arb_idx;
      start_d = 1'b1;
      cnt_d   = WORD_LOAD;
`ifdef SERDES_HDR_INSERT_EN
      state_d   = ST_HDR;
      par_d     = HDR_WORD;
      hdr_buf_d = req_words[arb_idx];
`else
      state_d   = ST_SEND;
      par_d     = req_words[arb_idx];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      par_q     <= '0;
      start_q   <= 1'b0;
      gid_q     <= '0;
      ptr_q     <= IDX_W'(N_REQ - 1);
`ifdef SERDES_HDR_INSERT_EN
      hdr_buf_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      start_q   <= start_d;
      gid_q     <= gid_d;
      ptr_q     <= ptr_d;
`ifdef SERDES_HDR_INSERT_EN
      hdr_buf_q <= hdr_buf_d;
`endif
    end
  end

  assign PAR_OUT   = par_q;
  assign SER_START = start_q;
  assign GRANT_ID  = gid_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Scoreboard bench for serdes_tx_scheduler (default and GAP_CYCLES=0 instances).
// Expectations follow SERDES_HDR_INSERT_EN when it is defined.
module tb_serdes_tx_scheduler;

  localparam int unsigned W = 16;
  localparam int unsigned G = 7;
  localparam logic [15:0] HW = 16'hC5AF;
`ifdef SERDES_HDR_INSERT_EN
  localparam int unsigned HS = W;
`else
  localparam int unsigned HS = 0;
`endif
  localparam int unsigned P  = HS + W + G;
  localparam int unsigned P0 = HS + W;

  typedef struct packed {
    logic [15:0] par;
    logic        start;
    logic        busy;
    logic [1:0]  gid;
    logic [3:0]  ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, en0;
  logic [3:0]  valid, valid0, ready, ready0;
  logic [63:0] data, data0;
  logic [15:0] par, par0;
  logic        start, start0, busy, busy0;
  logic [1:0]  gid, gid0;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serdes_tx_scheduler #(
    .N_REQ(4), .WORD_CYCLES(W), .GAP_CYCLES(G), .HDR_WORD(HW)
  ) u_dut (
    .CLK(clk), .RESET(rst), .ENABLE(en), .REQ_VALID(valid), .REQ_DATA(data),
    .REQ_READY(ready), .PAR_OUT(par), .SER_START(start), .GRANT_ID(gid), .BUSY(busy)
  );

  serdes_tx_scheduler #(
    .N_REQ(4), .WORD_CYCLES(W), .GAP_CYCLES(0), .HDR_WORD(HW)
  ) u_dut0 (
    .CLK(clk), .RESET(rst), .ENABLE(en0), .REQ_VALID(valid0), .REQ_DATA(data0),
    .REQ_READY(ready0), .PAR_OUT(par0), .SER_START(start0), .GRANT_ID(gid0), .BUSY(busy0)
  );

  function automatic exp_t obs_main();
    return exp_t'({par, start, busy, gid, ready});
  endfunction

  function automatic exp_t obs_gap0();
    return exp_t'({par0, start0, busy0, gid0, ready0});
  endfunction

  task automatic push_slot(input logic [1:0] g, input logic [15:0] d,
                           input int unsigned gap, input logic [3:0] nready);
    exp_t e;
    for (int unsigned i = 0; i < HS; i++) begin
      e = exp_t'({HW, (i == 0), 1'b1, g, 4'b0000});
      sb.push_back(e);
    end
    for (int unsigned i = 0; i < W; i++) begin
      e = exp_t'({d, (i == 0), 1'b1, g, (gap == 0 && i == W - 1) ? nready : 4'b0000});
      sb.push_back(e);
    end
    for (int unsigned i = 0; i < gap; i++) begin
      e = exp_t'({16'h0000, 1'b0, 1'b1, g, (i == gap - 1) ? nready : 4'b0000});
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; valid = '0; valid0 = '0; en = 1'b1; en0 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (obs_main() !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_main: got %h exp %h", obs_main(), exp_t'(0));
    end
    n_tests++;
    if (obs_gap0() !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_gap0: got %h exp %h", obs_gap0(), exp_t'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    int   idx;
    do_reset();
    data[15:0] = 16'hC5AF; valid = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b exp 0001", ready);
    end
    push_slot(2'd0, 16'hC5AF, G, 4'b0000);
    @(posedge clk); #1 valid = '0;
    idx = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (obs_main() !== e) begin
        n_fail++; $display("FAIL single_cyc%0d: got %h exp %h", idx, obs_main(), e);
      end
      idx++;
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || par !== 16'h0 || ready !== 4'b0) begin
      n_fail++; $display("FAIL single_idle: got busy=%b par=%h ready=%b exp 0/0000/0000", busy, par, ready);
    end
  endtask

  task automatic test_all4();
    exp_t        e;
    int unsigned last_start;
    int          n_start;
    do_reset();
    data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    valid = 4'b1111;
    @(negedge clk);
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++; $display("FAIL all4_ready0: got %b exp 0001", ready);
    end
    push_slot(2'd0, 16'h1111, G, 4'b0010);
    push_slot(2'd1, 16'h2222, G, 4'b0100);
    push_slot(2'd2, 16'h3333, G, 4'b1000);
    push_slot(2'd3, 16'h4444, G, 4'b0001);
    push_slot(2'd0, 16'h1111, G, 4'b0000);
    last_start = 0;
    n_start    = 0;
    for (int unsigned idx = 0; idx < 5 * P; idx++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (obs_main() !== e) begin
        n_fail++; $display("FAIL all4_cyc%0d: got %h exp %h", idx, obs_main(), e);
      end
      if (start === 1'b1 && !e.start) n_start++;
      if (e.start && idx >= HS && ((idx - HS) % P) == 0) begin
        if (n_start > 0) begin
          n_tests++;
          if (cyc - last_start != P) begin
            n_fail++; $display("FAIL all4_period: got %0d exp %0d", cyc - last_start, P);
          end
        end
        last_start = cyc;
        n_start++;
      end
      if (idx == 4 * P - 1) begin
        @(posedge clk); #1 valid = '0;
      end
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || ready !== 4'b0) begin
      n_fail++; $display("FAIL all4_idle: got busy=%b ready=%b exp 0/0000", busy, ready);
    end
  endtask

  task automatic test_gap0();
    exp_t e;
    do_reset();
    data0  = {16'h0000, 16'h0000, 16'hBEEF, 16'hCAFE};
    valid0 = 4'b0011;
    @(negedge clk);
    n_tests++;
    if (ready0 !== 4'b0001) begin
      n_fail++; $display("FAIL gap0_ready: got %b exp 0001", ready0);
    end
    push_slot(2'd0, 16'hCAFE, 0, 4'b0010);
    push_slot(2'd1, 16'hBEEF, 0, 4'b0000);
    for (int unsigned idx = 0; idx < 2 * P0; idx++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (obs_gap0() !== e) begin
        n_fail++; $display("FAIL gap0_cyc%0d: got %h exp %h", idx, obs_gap0(), e);
      end
      if (idx == P0 - 1) begin
        @(posedge clk); #1 valid0 = '0;
      end
    end
    @(negedge clk);
    n_tests++;
    if (busy0 !== 1'b0 || par0 !== 16'h0) begin
      n_fail++; $display("FAIL gap0_idle: got busy=%b par=%h exp 0/0000", busy0, par0);
    end
  endtask

  task automatic test_enable();
    exp_t e;
    do_reset();
    data[15:0] = 16'h5A5A; valid = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++; $display("FAIL en_ready: got %b exp 0001", ready);
    end
    push_slot(2'd0, 16'h5A5A, G, 4'b0000);
    @(posedge clk); #1;
    for (int unsigned idx = 0; idx < P; idx++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (obs_main() !== e) begin
        n_fail++; $display("FAIL en_cyc%0d: got %h exp %h", idx, obs_main(), e);
      end
      if (idx == HS + 4) begin
        @(posedge clk); #1 en = 1'b0;
      end
    end
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_t'({16'h0, 1'b0, 1'b0, 2'd0, 4'b0})) begin
        n_fail++; $display("FAIL en_idle%0d: got %h exp %h", k, obs_main(),
                           exp_t'({16'h0, 1'b0, 1'b0, 2'd0, 4'b0}));
      end
    end
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++; $display("FAIL en_regrant_ready: got %b exp 0001", ready);
    end
    @(posedge clk); #1 valid = '0;
    @(negedge clk);
    n_tests++;
    if (start !== 1'b1 || busy !== 1'b1 || par !== ((HS > 0) ? HW : 16'h5A5A)) begin
      n_fail++; $display("FAIL en_regrant_slot: got start=%b busy=%b par=%h exp 1/1/%h",
                         start, busy, par, (HS > 0) ? HW : 16'h5A5A);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    data  = {16'h0000, 16'h0000, 16'h0B0B, 16'h0A0A};
    valid = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++; $display("FAIL rmid_ready: got %b exp 0001", ready);
    end
    push_slot(2'd0, 16'h0A0A, G, 4'b0000);
    @(posedge clk); #1 valid = '0;
    for (int unsigned idx = 0; idx <= HS + 7; idx++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (obs_main() !== e) begin
        n_fail++; $display("FAIL rmid_cyc%0d: got %h exp %h", idx, obs_main(), e);
      end
    end
    sb.delete();
    @(posedge clk); #1 rst = 1'b1; valid = 4'b0011;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_main() !== exp_t'({16'h0, 1'b0, 1'b0, 2'd0, 4'b0001})) begin
      n_fail++; $display("FAIL rmid_after: got %h exp %h", obs_main(),
                         exp_t'({16'h0, 1'b0, 1'b0, 2'd0, 4'b0001}));
    end
    @(posedge clk); #1 valid = '0;
    @(negedge clk);
    n_tests++;
    if (start !== 1'b1 || gid !== 2'd0 || par !== ((HS > 0) ? HW : 16'h0A0A)) begin
      n_fail++; $display("FAIL rmid_regrant: got start=%b gid=%0d par=%h exp 1/0/%h",
                         start, gid, par, (HS > 0) ? HW : 16'h0A0A);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; en0 = 1'b1;
    valid = '0; valid0 = '0; data = '0; data0 = '0;
    test_reset();
    test_single();
    test_all4();
    test_gap0();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serdes_tx_scheduler.md
Name: serdes_tx_scheduler

Overview:
- Sequences and shares one 16-bit serializer_unit_cell_16 lane between N requesters.
- Round-robin arbitration accepts one 16-bit word per grant over a valid/ready handshake.
- Drives the word onto the serializer's parallel input for one serialization slot, then forces zeros for a clear gap, then re-arbitrates.
- Sits between the TX word sources and the serializer PAR_IN/COUNT interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_CYCLES, 16, cycles a word is held on PAR_OUT (one serialization slot, >=2).
- GAP_CYCLES, 7, cycles of all-zero PAR_OUT after each word (0 allowed = no gap).
- HDR_WORD, 16'hC5AF, header word used only under SERDES_HDR_INSERT_EN.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  permits new grants; an in-flight word/gap always completes.
- REQ_VALID  in  N_REQ  per-requester word available.
- REQ_DATA  in  16*N_REQ  per-requester word; requester i at bits [16i+15:16i].
- REQ_READY  out  N_REQ  one-hot accept; a transfer occurs on VALID&READY.
- PAR_OUT  out  16  registered word to serializer PAR_IN.
- SER_START  out  1  one-cycle pulse in the first cycle of each slot.
- GRANT_ID  out  clog2(N_REQ)  index of the requester owning the current slot.
- BUSY  out  1  high in every non-IDLE state.

Behaviour:
- Reset values: state IDLE, PAR_OUT=0, SER_START=0, GRANT_ID=0, BUSY=0, REQ_READY=0. Round-robin pointer = N_REQ-1, so requester 0 has first priority.
- States: IDLE, SEND, GAP (plus HDR under the optional feature).
- Grant window: state==IDLE, or the last GAP cycle (or the last SEND cycle when GAP_CYCLES=0), with ENABLE=1 and |REQ_VALID.
  - In the grant window, REQ_READY is combinational and one-hot: the first valid index searching from ptr+1 mod N_REQ upward with wrap.
  - REQ_READY=0 outside the grant window.
- On the accept edge:
  - PAR_OUT<=REQ_DATA[g], GRANT_ID<=g, ptr<=g, SER_START<=1 for that next cycle.
  - State->SEND; slot counter loads WORD_CYCLES-1.
- SEND:
  - PAR_OUT held stable; counter decrements each cycle.
  - At counter==0: go to GAP (counter loads GAP_CYCLES-1) if GAP_CYCLES>0; otherwise grant window or IDLE.
- GAP:
  - PAR_OUT=0; counter decrements.
  - At 0: new grant -> SEND back-to-back; else -> IDLE.
- Latency: accept in cycle t -> word on PAR_OUT in cycles t+1..t+WORD_CYCLES. Back-to-back period is WORD_CYCLES+GAP_CYCLES (23 at defaults).
- PAR_OUT=0 in IDLE. GRANT_ID holds its last value in IDLE.
- ENABLE deasserted mid-slot: current SEND and GAP finish normally; no grant; then IDLE.
- VALID dropped without READY: no transfer and no penalty. Requesters must hold DATA while VALID is high.
- Simultaneous requests: exactly one READY per window; fairness is strict rotation.
- RESET mid-slot: all outputs return to reset values on that edge. No partial word is resumed.
- Counter width is clog2(max(WORD_CYCLES, GAP_CYCLES)+1).

Optional Feature:
- Macro: SERDES_HDR_INSERT_EN.
- Defined:
  - Each accepted word is preceded by an HDR slot of WORD_CYCLES cycles with PAR_OUT=HDR_WORD, SER_START pulsing at the HDR start and again at the SEND start.
  - Accepted data is buffered in an internal register during HDR.
  - Back-to-back period becomes 2*WORD_CYCLES+GAP_CYCLES.
- Undefined: no HDR state or data buffer; behaviour exactly as above.

Decomposition:
- Package serdes_sched_pkg holds:
  - state enum (IDLE, HDR, SEND, GAP);
  - default WORD_CYCLES and GAP_CYCLES constants;
  - default header constant.
- Sub-module rr_arbiter (N-bit round-robin: request vector + pointer -> one-hot grant + index), purely combinational, reused by other lanes.

Test Plan:
- Single request: REQ_VALID=0001, data 16'hC5AF in IDLE.
  - READY[0] for 1 cycle.
  - PAR_OUT=C5AF for 16 cycles, SER_START only in the first.
  - 7 zero cycles, then IDLE with BUSY=0.
- All 4 valid continuously: grants 0,1,2,3,0.
  - Each SER_START exactly 23 cycles apart.
  - GRANT_ID sequence matches.
- GAP_CYCLES=0 build, two requesters: word 2 follows word 1 with no zero cycle; period 16.
- ENABLE dropped at SEND cycle 5: word and gap complete, no further READY, IDLE; re-enable -> next grant in the following cycle.
- RESET asserted at SEND cycle 8: next cycle PAR_OUT=0, BUSY=0, ptr reset.
  - With requests 1 and 0 both valid afterward, requester 0 is granted first.
- SERDES_HDR_INSERT_EN, data 16'h1234: PAR_OUT=C5AF for 16 cycles, then 1234 for 16, then 7 zeros; two SER_START pulses 16 apart.
